// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: IF/ID operand info, ID/EX load info, redirect and
// dmem busy in; pipeline register enables, state and stall counter out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned REG_W = 5;

    logic [REG_W-1:0] ID_rs1;
    logic [REG_W-1:0] ID_rs2;
    logic             ID_uses_rs1;
    logic             ID_uses_rs2;
    logic [REG_W-1:0] EX_rd;
    logic             EX_DmemREB;
    logic             Redirect;
    logic             DmemBusy;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic             IDEXWrite;
    logic             EXMEMWrite;
    logic [1:0]       HazardState;
    logic [CNT_W-1:0] StallCount;

    // Pipeline side: supplies hazard sources, consumes enables.
    modport master (
        output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_rd, EX_DmemREB,
               Redirect, DmemBusy,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXWrite, EXMEMWrite,
               HazardState, StallCount
    );

    // Controller side.
    modport slave (
        input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_rd, EX_DmemREB,
               Redirect, DmemBusy,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXWrite, EXMEMWrite,
               HazardState, StallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: owns all stall, flush, bubble and
// freeze decisions, with zero-cycle response to hazards, redirects and dmem busy.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input logic                 CLK,
    input logic                 RSTN,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned FC_W = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOADUSE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_e;

    state_e           state;
    state_e           state_nxt;
    state_e           saved;
    state_e           saved_nxt;
    state_e           eff_state;
    logic [FC_W-1:0]  fcnt;
    logic [FC_W-1:0]  fcnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             idex_we;
    logic             exmem_we;

    // Leaving MEMWAIT behaves exactly like the state that was frozen.
    assign eff_state = (state == ST_MEMWAIT) ? saved : state;

    assign load_use = !hz.EX_DmemREB && (hz.EX_rd != '0) &&
                      ((hz.ID_uses_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                       (hz.ID_uses_rs2 && (hz.ID_rs2 == hz.EX_rd)));

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_RUN;
            saved <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state logic: busy > redirect > flush > load-use
    always_comb begin
        state_nxt = state;
        saved_nxt = saved;
        fcnt_nxt  = fcnt;
        if (hz.DmemBusy) begin
            state_nxt = ST_MEMWAIT;
            if (state != ST_MEMWAIT) begin
                saved_nxt = state;
            end
        end else if (hz.Redirect) begin
            if (FLUSH_CYCLES > 0) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = FC_W'(FLUSH_CYCLES);
            end else begin
                state_nxt = ST_RUN;
            end
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    fcnt_nxt  = fcnt - FC_W'(1);
                    state_nxt = (fcnt == FC_W'(1)) ? ST_RUN : ST_FLUSH;
                end
                ST_RUN:  state_nxt = load_use ? ST_LOADUSE : ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // Output logic; reset forces the squash/freeze pattern immediately
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        if (!RSTN) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
        end else if (hz.DmemBusy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (hz.Redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                ST_RUN: begin
                    if (load_use) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.PCWrite     = pc_we;
    assign hz.IFIDWrite   = ifid_we;
    assign hz.IFIDFlush   = ifid_flush;
    assign hz.IDEXBubble  = idex_bubble;
    assign hz.IDEXWrite   = idex_we;
    assign hz.EXMEMWrite  = exmem_we;
    assign hz.HazardState = state;
    assign hz.StallCount  = stall_cnt;

endmodule
